mipi_dphy_clk_reconfig_ctl: RTL and testbench

- Sequencer that retunes the serial-clock MMCM of the D-PHY clock generator at run time, through its clocking-wizard AXI4-Lite dynamic-reconfiguration port.
- Holds the D-PHY link quiet, writes the new divider and phase words, triggers the load, then waits for lock and a settle period before releasing the link.
- Runs in the core_clk domain. It is the only AXI4-Lite master on that MMCM port. It has a write-only master port.

---
 rtl/mipi_dphy_clk_reconfig_ctl.sv | 252 +++++++++++++++++++++++++
 tb/tb_mipi_dphy_clk_reconfig_ctl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_dphy_clk_reconfig_ctl.sv
// Run-time retune sequencer for the D-PHY serial-clock MMCM over its AXI4-Lite DRP port.
// Optional macro MIPI_DPHY_CLK_RECONFIG_AUTOSTART_EN: fire one sequence with the DEF_* values after reset.
module mipi_dphy_clk_reconfig_ctl #(
  parameter int          ADDR_BITS      = 11,
  parameter int          TIMEOUT_CYCLES = 1048576,
  parameter int          SETTLE_CYCLES  = 64,
  parameter int          LOCK_STABLE    = 16,
  parameter logic [7:0]  DEF_MULT       = 8'd20,
  parameter logic [7:0]  DEF_DIV        = 8'd1,
  parameter logic [7:0]  DEF_CLK0_DIV   = 8'd1,
  parameter logic [7:0]  DEF_CLK1_DIV   = 8'd1,
  parameter logic [31:0] DEF_CLK1_PHASE = 32'd90000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [7:0]           cfg_mult,
  input  logic [7:0]           cfg_div,
  input  logic [7:0]           cfg_clk0_div,
  input  logic [7:0]           cfg_clk1_div,
  input  logic [31:0]          cfg_clk1_phase,
  input  logic                 mmcm_locked,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 link_hold,
  output logic [ADDR_BITS-1:0] m_awaddr,
  output logic [2:0]           m_awprot,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wstrb,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_WR_ISSUE, S_WR_RESP, S_SETTLE, S_LOCKWAIT, S_DONE, S_ERR
  } state_t;

  state_t          state_r, state_next;
  logic [3:0]      hold_cnt_r;
  logic [2:0]      idx_r;
  logic [TW-1:0]   timer_r, timer_inc_s;
  logic [SW-1:0]   stable_r;
  logic [31:0]     timer_nx_s, stable_nx_s;
  logic [7:0]      mult_r, div_r, clk0_div_r, clk1_div_r;
  logic [31:0]     phase_r;
  logic            locked_meta_r, locked_sync_r;
  logic            auto_fire_s, start_s, aw_pend_s, w_pend_s;

  assign m_awprot = 3'b000;
  assign m_wstrb  = 4'hF;

`ifdef MIPI_DPHY_CLK_RECONFIG_AUTOSTART_EN
  logic auto_pend_r;

  // One-shot internal start on the first clock after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) auto_pend_r <= 1'b1;
    else          auto_pend_r <= 1'b0;
  end
  assign auto_fire_s = auto_pend_r;
`else
  assign auto_fire_s = 1'b0;
`endif

  assign start_s     = start | auto_fire_s;
  assign aw_pend_s   = m_awvalid & ~m_awready;
  assign w_pend_s    = m_wvalid & ~m_wready;
  assign timer_inc_s = (timer_r == {TW{1'b1}}) ? timer_r : timer_r + TW'(1);
  assign timer_nx_s  = 32'(timer_r) + 32'd1;
  assign stable_nx_s = locked_sync_r ? (32'(stable_r) + 32'd1) : 32'd0;

  function automatic logic [ADDR_BITS-1:0] wr_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    wr_addr = ADDR_BITS'(12'h200);
      3'd1:    wr_addr = ADDR_BITS'(12'h208);
      3'd2:    wr_addr = ADDR_BITS'(12'h20C);
      3'd3:    wr_addr = ADDR_BITS'(12'h214);
      3'd4:    wr_addr = ADDR_BITS'(12'h218);
      default: wr_addr = ADDR_BITS'(12'h25C);
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] idx);
    case (idx)
      3'd0:    wr_data = {16'h0000, mult_r, div_r};
      3'd1:    wr_data = {24'h000000, clk0_div_r};
      3'd2:    wr_data = 32'h00000000;
      3'd3:    wr_data = {24'h000000, clk1_div_r};
      3'd4:    wr_data = phase_r;
      default: wr_data = 32'h00000003;
    endcase
  endfunction

  // Double-flop the asynchronous MMCM lock indication
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta_r <= 1'b0;
      locked_sync_r <= 1'b0;
    end else begin
      locked_meta_r <= mmcm_locked;
      locked_sync_r <= locked_meta_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_next;
  end

  // Next-state logic; stable lock takes priority over the timeout
  always_comb begin
    state_next = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_s) state_next = S_HOLD;
        else         state_next = state_r;
      end
      S_HOLD: begin
        if (hold_cnt_r == 4'd15) state_next = S_WR_ISSUE;
        else                     state_next = S_HOLD;
      end
      S_WR_ISSUE: begin
        if (!aw_pend_s && !w_pend_s) state_next = S_WR_RESP;
        else                         state_next = S_WR_ISSUE;
      end
      S_WR_RESP: begin
        if (!m_bvalid)                state_next = S_WR_RESP;
        else if (m_bresp != 2'b00)    state_next = S_ERR;
        else if (idx_r == 3'd5)       state_next = S_SETTLE;
        else                          state_next = S_WR_ISSUE;
      end
      S_SETTLE: begin
        if (timer_nx_s >= 32'(SETTLE_CYCLES)) state_next = S_LOCKWAIT;
        else                                  state_next = S_SETTLE;
      end
      S_LOCKWAIT: begin
        if (stable_nx_s >= 32'(LOCK_STABLE))       state_next = S_DONE;
        else if (timer_nx_s >= 32'(TIMEOUT_CYCLES)) state_next = S_ERR;
        else                                        state_next = S_LOCKWAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath, AXI channel drivers and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      link_hold  <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_awaddr   <= '0;
      m_wdata    <= 32'd0;
      hold_cnt_r <= 4'd0;
      idx_r      <= 3'd0;
      timer_r    <= '0;
      stable_r   <= '0;
      mult_r     <= 8'd0;
      div_r      <= 8'd0;
      clk0_div_r <= 8'd0;
      clk1_div_r <= 8'd0;
      phase_r    <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_s) begin
            mult_r     <= auto_fire_s ? DEF_MULT       : cfg_mult;
            div_r      <= auto_fire_s ? DEF_DIV        : cfg_div;
            clk0_div_r <= auto_fire_s ? DEF_CLK0_DIV   : cfg_clk0_div;
            clk1_div_r <= auto_fire_s ? DEF_CLK1_DIV   : cfg_clk1_div;
            phase_r    <= auto_fire_s ? DEF_CLK1_PHASE : cfg_clk1_phase;
            busy       <= 1'b1;
            link_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'd0;
            hold_cnt_r <= 4'd0;
          end
        end
        S_HOLD: begin
          hold_cnt_r <= hold_cnt_r + 4'd1;
          if (state_next == S_WR_ISSUE) begin
            idx_r     <= 3'd0;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            m_awaddr  <= wr_addr(3'd0);
            m_wdata   <= wr_data(3'd0);
          end
        end
        S_WR_ISSUE: begin
          m_awvalid <= aw_pend_s;
          m_wvalid  <= w_pend_s;
          if (state_next == S_WR_RESP) m_bready <= 1'b1;
        end
        S_WR_RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            if (state_next == S_ERR) begin
              err_code <= 2'd1;
              error    <= 1'b1;
              busy     <= 1'b0;
            end else if (state_next == S_SETTLE) begin
              timer_r  <= '0;
              stable_r <= '0;
            end else begin
              idx_r     <= idx_r + 3'd1;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              m_awaddr  <= wr_addr(idx_r + 3'd1);
              m_wdata   <= wr_data(idx_r + 3'd1);
            end
          end
        end
        S_SETTLE: begin
          timer_r <= timer_inc_s;
        end
        S_LOCKWAIT: begin
          timer_r  <= timer_inc_s;
          stable_r <= SW'(stable_nx_s);
          if (state_next == S_DONE) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            link_hold <= 1'b0;
          end else if (state_next == S_ERR) begin
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd2;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_dphy_clk_reconfig_ctl.sv
// Bench for mipi_dphy_clk_reconfig_ctl: AXI-Lite slave model, lock pattern driver,
// table-driven and randomized sequences checked against a timeline model.
module tb_mipi_dphy_clk_reconfig_ctl;
  localparam int AB = 11;
  localparam int T  = 1000;
  localparam int S  = 64;
  localparam int LS = 16;

  logic clk = 1'b0;
  logic reset_n, start, locked;
  logic [7:0] cfg_mult, cfg_div, cfg_clk0_div, cfg_clk1_div;
  logic [31:0] cfg_clk1_phase;
  logic busy, done, error, link_hold;
  logic [1:0] err_code;
  logic [AB-1:0] m_awaddr;
  logic [2:0] m_awprot;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_wdata;
  logic [3:0] m_wstrb;
  logic [1:0] m_bresp;

  mipi_dphy_clk_reconfig_ctl #(
    .ADDR_BITS(AB), .TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S), .LOCK_STABLE(LS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_mult(cfg_mult), .cfg_div(cfg_div), .cfg_clk0_div(cfg_clk0_div),
    .cfg_clk1_div(cfg_clk1_div), .cfg_clk1_phase(cfg_clk1_phase),
    .mmcm_locked(locked), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .link_hold(link_hold),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // slave / lock-driver controls and observations
  int aw_delay, w_delay, err_idx, lk_rise, lk_glitch;
  int aw_seen, w_seen, nwr, load_p;
  bit aw_have, w_have, load_valid;
  logic [AB-1:0] cap_addr;
  logic [31:0] cap_data;
  logic [AB-1:0] addr_q[$];
  logic [31:0] data_q[$];

  typedef struct {
    logic [7:0] mult, div, c0, c1;
    logic [31:0] ph;
    int awd, wd, err_idx, rise, glitch;
    bit e_done, e_err;
    logic [1:0] e_code;
    bit e_hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit lock_fn(input int k, input int rise, input int glitch);
    if (rise < 0) return 1'b0;
    return (k >= rise) && !(glitch >= 0 && k == rise + glitch);
  endfunction

  // Cycles from the load-write response to done/error: locked is seen two cycles late,
  // ignored for S cycles, and must then hold for LS consecutive samples before T expires.
  function automatic int model_finish(input int rise, input int glitch, output bit ok);
    int run = 0;
    for (int c = S; c < T; c++) begin
      if (lock_fn(c - 1, rise, glitch)) run++;
      else run = 0;
      if (run >= LS) begin
        ok = 1'b1;
        return c + 1;
      end
    end
    ok = 1'b0;
    return T;
  endfunction

  function automatic logic [31:0] exp_addr(input int i);
    case (i)
      0: return 32'h200;
      1: return 32'h208;
      2: return 32'h20C;
      3: return 32'h214;
      4: return 32'h218;
      default: return 32'h25C;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input int i, input vec_t v);
    case (i)
      0: return {16'h0, v.mult, v.div};
      1: return {24'h0, v.c0};
      2: return 32'h0;
      3: return {24'h0, v.c1};
      4: return v.ph;
      default: return 32'h3;
    endcase
  endfunction

  // AXI4-Lite write slave with programmable ready delays, plus the MMCM lock pattern
  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'd0; locked = 1'b0;
    aw_have = 1'b0; w_have = 1'b0; aw_seen = 0; w_seen = 0;
    forever begin
      @(negedge clk);
      m_awready = 1'b0;
      m_wready  = 1'b0;
      if (!reset_n) begin
        aw_have = 1'b0; w_have = 1'b0; aw_seen = 0; w_seen = 0;
        m_bvalid = 1'b0; m_bresp = 2'd0; locked = 1'b0;
      end else begin
        if (m_bvalid) begin
          m_bvalid = 1'b0;
          m_bresp  = 2'd0;
        end else if (aw_have && w_have && m_bready) begin
          chk("aw_valid_cycles", aw_seen, aw_delay + 1);
          chk("w_valid_cycles", w_seen, w_delay + 1);
          addr_q.push_back(cap_addr);
          data_q.push_back(cap_data);
          m_bresp = (nwr == err_idx) ? 2'd2 : 2'd0;
          if (nwr == 5) begin
            load_p = cyc + 1;
            load_valid = 1'b1;
          end
          nwr++;
          m_bvalid = 1'b1;
          aw_have = 1'b0; w_have = 1'b0; aw_seen = 0; w_seen = 0;
        end
        if (m_awvalid) begin
          chk("aw_single_outstanding", aw_have, 0);
          if (!aw_have) begin
            aw_seen++;
            if (aw_seen == 1) cap_addr = m_awaddr;
            else chk("awaddr_stable", m_awaddr, cap_addr);
            chk("awprot", m_awprot, 0);
            if (aw_seen > aw_delay) begin
              m_awready = 1'b1;
              aw_have = 1'b1;
            end
          end
        end
        if (m_wvalid) begin
          chk("w_single_outstanding", w_have, 0);
          if (!w_have) begin
            w_seen++;
            if (w_seen == 1) cap_data = m_wdata;
            else chk("wdata_stable", m_wdata, cap_data);
            chk("wstrb", m_wstrb, 4'hF);
            if (w_seen > w_delay) begin
              m_wready = 1'b1;
              w_have = 1'b1;
            end
          end
        end
        locked = load_valid ? lock_fn(cyc + 1 - load_p, lk_rise, lk_glitch) : 1'b0;
      end
    end
  end

  task automatic run_seq(input vec_t v, input string tag);
    int fin, nexp, off;
    bit ok;
    aw_delay = v.awd; w_delay = v.wd; err_idx = v.err_idx;
    lk_rise = v.rise; lk_glitch = v.glitch;
    addr_q.delete(); data_q.delete();
    load_valid = 1'b0; nwr = 0; load_p = 0;
    @(negedge clk);
    cfg_mult = v.mult; cfg_div = v.div; cfg_clk0_div = v.c0; cfg_clk1_div = v.c1;
    cfg_clk1_phase = v.ph; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_mult = 8'($urandom); cfg_div = 8'($urandom); cfg_clk0_div = 8'($urandom);
    cfg_clk1_div = 8'($urandom); cfg_clk1_phase = $urandom;
    chk({tag, " busy_on"}, busy, 1);
    chk({tag, " hold_on"}, link_hold, 1);
    chk({tag, " flags_clear"}, 32'({done, error, err_code}), 0);
    fin = -1;
    for (int n = 0; n < 3000 && fin < 0; n++) begin
      @(negedge clk);
      if (!busy) fin = cyc;
      start = (n == 5);
    end
    start = 1'b0;
    chk({tag, " finished"}, fin >= 0, 1);
    nexp = (v.err_idx >= 0) ? v.err_idx + 1 : 6;
    chk({tag, " nwrites"}, addr_q.size(), nexp);
    for (int i = 0; i < nexp && i < addr_q.size(); i++) begin
      chk({tag, " wr_addr"}, 32'(addr_q[i]), exp_addr(i));
      chk({tag, " wr_data"}, data_q[i], exp_data(i, v));
    end
    chk({tag, " done"}, done, v.e_done);
    chk({tag, " error"}, error, v.e_err);
    chk({tag, " err_code"}, err_code, v.e_code);
    chk({tag, " link_hold"}, link_hold, v.e_hold);
    if (v.err_idx < 0) begin
      off = model_finish(v.rise, v.glitch, ok);
      chk({tag, " finish_cycle"}, fin - load_p, off);
    end
  endtask

  vec_t vt[5];
  logic [31:0] lit_d[6];

  initial begin
    bit seen;
    reset_n = 1'b0; start = 1'b0;
    cfg_mult = 8'd0; cfg_div = 8'd0; cfg_clk0_div = 8'd0; cfg_clk1_div = 8'd0; cfg_clk1_phase = 32'd0;
    aw_delay = 0; w_delay = 0; err_idx = -1; lk_rise = 100; lk_glitch = -1;
    nwr = 0; load_p = 0; load_valid = 1'b0;

    vt[0] = '{8'd20, 8'd1, 8'd1, 8'd1, 32'd90000, 0, 0, -1, 100, -1, 1'b1, 1'b0, 2'd0, 1'b0};
    vt[1] = '{8'd33, 8'd2, 8'd4, 8'd4, 32'd45000, 2, 0, -1, 100, -1, 1'b1, 1'b0, 2'd0, 1'b0};
    vt[2] = '{8'd20, 8'd1, 8'd1, 8'd1, 32'd90000, 0, 0, 3, 100, -1, 1'b0, 1'b1, 2'd1, 1'b1};
    vt[3] = '{8'd20, 8'd1, 8'd2, 8'd2, 32'hFFFE_7960, 1, 1, -1, -1, -1, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[4] = '{8'd40, 8'd3, 8'd2, 8'd2, 32'd0, 0, 2, -1, 80, 10, 1'b1, 1'b0, 2'd0, 1'b0};
    lit_d = '{32'h00001401, 32'h1, 32'h0, 32'h1, 32'h00015F90, 32'h3};

    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done_error", 32'({done, error}), 0);
    chk("rst err_code", err_code, 0);
    chk("rst link_hold", link_hold, 0);
    chk("rst valids", 32'({m_awvalid, m_wvalid, m_bready}), 0);
    chk("rst awaddr", 32'(m_awaddr), 0);
    chk("rst wdata", m_wdata, 0);
    #2 reset_n = 1'b1;

`ifdef MIPI_DPHY_CLK_RECONFIG_AUTOSTART_EN
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (n > 2 && !busy) seen = 1'b1;
    end
    chk("autostart done", done, 1);
`endif

    for (int i = 0; i < 5; i++) begin
      run_seq(vt[i], "vec");
      if (i == 0) begin
        for (int k = 0; k < 6 && k < data_q.size(); k++)
          chk("nominal literal data", data_q[k], lit_d[k]);
      end
    end

    for (int r = 0; r < 20; r++) begin
      vec_t v;
      bit ok;
      int off;
      v.mult = 8'($urandom); v.div = 8'($urandom); v.c0 = 8'($urandom); v.c1 = 8'($urandom);
      v.ph = $urandom;
      v.awd = int'($urandom_range(0, 3));
      v.wd  = int'($urandom_range(0, 3));
      v.err_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      v.rise    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(40, 400));
      v.glitch  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30));
      if (v.err_idx >= 0) begin
        v.e_done = 1'b0; v.e_err = 1'b1; v.e_code = 2'd1; v.e_hold = 1'b1;
      end else begin
        off = model_finish(v.rise, v.glitch, ok);
        v.e_done = ok; v.e_err = !ok; v.e_code = ok ? 2'd0 : 2'd2; v.e_hold = !ok;
      end
      run_seq(v, "rand");
    end

    // asynchronous reset while a write is stalled on awready
    aw_delay = 1000000; w_delay = 0; err_idx = -1; load_valid = 1'b0; nwr = 0;
    addr_q.delete(); data_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (m_awvalid) seen = 1'b1;
    end
    chk("reached wr_issue", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst valids", 32'({m_awvalid, m_wvalid, m_bready}), 0);
    chk("async rst busy", busy, 0);
    chk("async rst link_hold", link_hold, 0);
    aw_delay = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(negedge clk);
`ifdef MIPI_DPHY_CLK_RECONFIG_AUTOSTART_EN
    chk("post rst rerun busy", busy, 1);
`else
    chk("post rst idle busy", busy, 0);
    chk("post rst idle awvalid", m_awvalid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
